// File: rtl/agc_pkg.sv
// Shared definitions for the AGC error integrator.
// Holds the default widths, the signed range helpers, the saturate-to-width
// function used by the difference stage and the saturating adder, and the
// per-sample update kind decoded in the accumulate stage.
package agc_pkg;

    localparam int AGC_BWIDTH     = 18;
    localparam int AGC_AWIDTH     = 30;
    localparam int AGC_DWIDTH     = 27;
    localparam int AGC_OUTWIDTH   = 48;
    localparam int AGC_NUM_CH     = 4;
    localparam int AGC_CH_WIDTH   = (AGC_NUM_CH > 1) ? $clog2(AGC_NUM_CH) : 1;
    localparam int AGC_LEAK_SHIFT = 12;

    // Signed range of a w-bit two's complement value (w <= 63).
    function automatic longint smax(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint smin(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    localparam longint OUT_MAX = smax(AGC_OUTWIDTH);
    localparam longint OUT_MIN = smin(AGC_OUTWIDTH);
    localparam longint DIF_MAX = smax(AGC_DWIDTH);
    localparam longint DIF_MIN = smin(AGC_DWIDTH);

    // Clip x into the signed w-bit range; caller truncates the result to w bits.
    function automatic longint sat_to_width(input longint x, input int w);
        longint hi;
        longint lo;
        hi = smax(w);
        lo = smin(w);
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

    // What the accumulate stage does with the sample currently in it.
    typedef enum logic [1:0] {
        UPD_NONE  = 2'd0,   // no valid sample
        UPD_ACC   = 2'd1,   // integrate the product
        UPD_HOLD  = 2'd2,   // frozen: report current value, no change
        UPD_CLEAR = 2'd3    // coincident clear of the same channel
    } upd_kind_e;

endpackage

// File: rtl/agc_error_integrator_if.sv
// Sample/result bundle of the AGC error integrator.
// slave : the integrator side (samples and clear in, results out).
// master: the driver side (detector/level estimator and gain update stage).
// Inputs : Valid, Ch_Id, Port_Data_A, R_level, Error_Coefficient, Freeze,
//          Clear_Ch, Clear_Id
// Outputs: Valid_out_error, Ch_Out, Error_Out, Sat_Flag
interface agc_error_integrator_if
    import agc_pkg::*;
#(
    parameter int BWIDTH   = AGC_BWIDTH,
    parameter int AWIDTH   = AGC_AWIDTH,
    parameter int DWIDTH   = AGC_DWIDTH,
    parameter int OUTWIDTH = AGC_OUTWIDTH,
    parameter int CH_WIDTH = AGC_CH_WIDTH
) ();

    logic                       Valid;
    logic [CH_WIDTH-1:0]        Ch_Id;
    logic signed [AWIDTH-1:0]   Port_Data_A;
    logic signed [DWIDTH-1:0]   R_level;
    logic signed [BWIDTH-1:0]   Error_Coefficient;
    logic                       Freeze;
    logic                       Clear_Ch;
    logic [CH_WIDTH-1:0]        Clear_Id;

    logic                       Valid_out_error;
    logic [CH_WIDTH-1:0]        Ch_Out;
    logic signed [OUTWIDTH-1:0] Error_Out;
    logic                       Sat_Flag;

    modport slave (
        input  Valid, Ch_Id, Port_Data_A, R_level, Error_Coefficient,
               Freeze, Clear_Ch, Clear_Id,
        output Valid_out_error, Ch_Out, Error_Out, Sat_Flag
    );

    modport master (
        output Valid, Ch_Id, Port_Data_A, R_level, Error_Coefficient,
               Freeze, Clear_Ch, Clear_Id,
        input  Valid_out_error, Ch_Out, Error_Out, Sat_Flag
    );

endinterface

// File: rtl/agc_sat_add.sv
// Signed saturating adder.
// Ports: a, b (signed W) addends; sum (signed W) result clipped to the
// W-bit range; ovf high when clipping occurred.
// The exact W+1-bit sum is formed first so the clip decision is never
// based on a wrapped value. W must not exceed 62.
module agc_sat_add
    import agc_pkg::*;
#(
    parameter int W = AGC_OUTWIDTH
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    logic signed [W:0] wide;
    longint            wide_l;
    longint            clipped_l;

    assign wide      = $signed({a[W-1], a}) + $signed({b[W-1], b});
    assign wide_l    = longint'(wide);
    assign clipped_l = sat_to_width(wide_l, W);
    assign sum       = W'(clipped_l);
    assign ovf       = (clipped_l != wide_l);

endmodule

// File: rtl/agc_error_integrator.sv
// Multi-channel time-multiplexed AGC error integrator.
// Per valid sample: acc[ch] <= sat(acc[ch] + Coeff * sat(R_level - Data)).
// Ports: clk, rst_n (asynchronous, active-low) and bus (slave modport of
// agc_error_integrator_if) carrying samples, freeze, clear and results.
// Pipeline: S1 input register, S2 saturated difference, S3 product
// register, then accumulate/output, so a sample taken at edge n is
// reported at edge n+3. The accumulator is read and written in the same
// cycle, so back-to-back samples of one channel need no forwarding.
// Build option: define AGC_ERR_LEAK_EN for leaky integration
// (acc - (acc >>> LEAK_SHIFT) + prod); otherwise a pure integrator.
module agc_error_integrator
    import agc_pkg::*;
#(
    parameter int BWIDTH     = AGC_BWIDTH,
    parameter int AWIDTH     = AGC_AWIDTH,
    parameter int DWIDTH     = AGC_DWIDTH,
    parameter int OUTWIDTH   = AGC_OUTWIDTH,
    parameter int NUM_CH     = AGC_NUM_CH,
    parameter int CH_WIDTH   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int LEAK_SHIFT = AGC_LEAK_SHIFT
) (
    input logic                    clk,
    input logic                    rst_n,
    agc_error_integrator_if.slave  bus
);

    localparam int EXT_W  = ((AWIDTH > DWIDTH) ? AWIDTH : DWIDTH) + 1;
    localparam int PROD_W = DWIDTH + BWIDTH;

`ifdef AGC_ERR_LEAK_EN
    localparam bit LEAK_ON = 1'b1;
`else
    localparam bit LEAK_ON = 1'b0;
`endif

    // S1 registers
    logic                       v1_reg;
    logic [CH_WIDTH-1:0]        ch1_reg;
    logic                       frz1_reg;
    logic signed [AWIDTH-1:0]   data1_reg;
    logic signed [DWIDTH-1:0]   r1_reg;
    logic signed [BWIDTH-1:0]   coef1_reg;

    // S2 registers
    logic                       v2_reg;
    logic [CH_WIDTH-1:0]        ch2_reg;
    logic                       frz2_reg;
    logic signed [DWIDTH-1:0]   diff2_reg;
    logic signed [BWIDTH-1:0]   coef2_reg;

    // S3 registers
    logic                       v3_reg;
    logic [CH_WIDTH-1:0]        ch3_reg;
    logic                       frz3_reg;
    logic signed [OUTWIDTH-1:0] prod3_reg;

    // Accumulators and outputs
    logic signed [OUTWIDTH-1:0] acc_reg [NUM_CH];
    logic                       valid_out_reg;
    logic [CH_WIDTH-1:0]        ch_out_reg;
    logic signed [OUTWIDTH-1:0] error_out_reg;
    logic                       sat_flag_reg;

    // Combinational
    logic                       ch_in_range;
    logic signed [EXT_W-1:0]    diff_wide;
    logic signed [DWIDTH-1:0]   diff_sat;
    logic signed [PROD_W-1:0]   prod_full;
    logic signed [OUTWIDTH-1:0] acc_cur;
    logic signed [OUTWIDTH-1:0] leak_term;
    logic signed [OUTWIDTH-1:0] acc_base;
    logic signed [OUTWIDTH-1:0] sum_sat;
    logic                       sum_ovf;
    logic                       clear_hit;
    upd_kind_e                  upd_kind;
    logic [NUM_CH-1:0]          clr_sel;
    logic [NUM_CH-1:0]          upd_sel;

    // Samples for channels beyond NUM_CH are dropped at the input.
    assign ch_in_range = (int'(bus.Ch_Id) < NUM_CH);

    // Difference computed one bit wider than the widest operand, so it never
    // wraps before being clipped into the DWIDTH range.
    assign diff_wide = EXT_W'(r1_reg) - EXT_W'(data1_reg);
    assign diff_sat  = DWIDTH'(sat_to_width(longint'(diff_wide), DWIDTH));
    assign prod_full = PROD_W'(diff2_reg) * PROD_W'(coef2_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg    <= 1'b0;
            ch1_reg   <= '0;
            frz1_reg  <= 1'b0;
            data1_reg <= '0;
            r1_reg    <= '0;
            coef1_reg <= '0;
            v2_reg    <= 1'b0;
            ch2_reg   <= '0;
            frz2_reg  <= 1'b0;
            diff2_reg <= '0;
            coef2_reg <= '0;
            v3_reg    <= 1'b0;
            ch3_reg   <= '0;
            frz3_reg  <= 1'b0;
            prod3_reg <= '0;
        end else begin
            v1_reg    <= bus.Valid && ch_in_range;
            ch1_reg   <= bus.Ch_Id;
            frz1_reg  <= bus.Freeze;
            data1_reg <= bus.Port_Data_A;
            r1_reg    <= bus.R_level;
            coef1_reg <= bus.Error_Coefficient;

            v2_reg    <= v1_reg;
            ch2_reg   <= ch1_reg;
            frz2_reg  <= frz1_reg;
            diff2_reg <= diff_sat;
            coef2_reg <= coef1_reg;

            v3_reg    <= v2_reg;
            ch3_reg   <= ch2_reg;
            frz3_reg  <= frz2_reg;
            prod3_reg <= OUTWIDTH'(prod_full);
        end
    end

    assign acc_cur = acc_reg[ch3_reg];

    // The leak only shrinks the magnitude, so acc_base cannot overflow.
    assign leak_term = LEAK_ON ? (acc_cur >>> LEAK_SHIFT) : '0;
    assign acc_base  = acc_cur - leak_term;

    agc_sat_add #(
        .W (OUTWIDTH)
    ) u_sat_add (
        .a   (acc_base),
        .b   (prod3_reg),
        .sum (sum_sat),
        .ovf (sum_ovf)
    );

    assign clear_hit = bus.Clear_Ch && (bus.Clear_Id == ch3_reg);

    // A clear of the channel being updated takes priority over freeze and
    // integration; freeze also suppresses the leak.
    always_comb begin
        upd_kind = UPD_NONE;
        if (v3_reg) begin
            if (clear_hit)
                upd_kind = UPD_CLEAR;
            else if (frz3_reg)
                upd_kind = UPD_HOLD;
            else
                upd_kind = UPD_ACC;
        end
    end

    // Per-channel write selects: the clear port acts on its own, independent
    // of whatever sample sits in the pipeline.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sel
        assign clr_sel[gi] = bus.Clear_Ch && (int'(bus.Clear_Id) == gi);
        assign upd_sel[gi] = (upd_kind == UPD_ACC) && (int'(ch3_reg) == gi);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++)
                acc_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr_sel[i])
                    acc_reg[i] <= '0;
                else if (upd_sel[i])
                    acc_reg[i] <= sum_sat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out_reg <= 1'b0;
            ch_out_reg    <= '0;
            error_out_reg <= '0;
            sat_flag_reg  <= 1'b0;
        end else begin
            valid_out_reg <= v3_reg;
            sat_flag_reg  <= 1'b0;
            if (v3_reg)
                ch_out_reg <= ch3_reg;
            case (upd_kind)
                UPD_CLEAR: error_out_reg <= '0;
                UPD_HOLD:  error_out_reg <= acc_cur;
                UPD_ACC: begin
                    error_out_reg <= sum_sat;
                    sat_flag_reg  <= sum_ovf;
                end
                default:   error_out_reg <= error_out_reg;
            endcase
        end
    end

    assign bus.Valid_out_error = valid_out_reg;
    assign bus.Ch_Out          = ch_out_reg;
    assign bus.Error_Out       = error_out_reg;
    assign bus.Sat_Flag        = sat_flag_reg;

endmodule

// File: tb/tb_agc_error_integrator.sv
// Directed bench for agc_error_integrator (default build, no leak).
// Inputs change on the falling edge; outputs are checked on the falling
// edge, so a sample driven before tick k is reported after tick k+3.
module tb_agc_error_integrator;

    localparam longint OMAX   = 64'sd140737488355327;  // 2^47-1
    localparam longint PROD_C = 64'sd8796025782273;    // 131071*(2^26-1)

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_fail;
    int   n_total;

    agc_error_integrator_if bus ();

    agc_error_integrator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input int ch, input longint data,
                         input longint r, input longint coef, input logic frz);
        bus.Valid             = v;
        bus.Ch_Id             = 2'(ch);
        bus.Port_Data_A       = 30'(data);
        bus.R_level           = 27'(r);
        bus.Error_Coefficient = 18'(coef);
        bus.Freeze            = frz;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic clr(input logic en, input int id);
        bus.Clear_Ch = en;
        bus.Clear_Id = 2'(id);
    endtask

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input int ch,
                           input longint val, input logic sat);
        chk({tag, ".valid"}, longint'(bus.Valid_out_error), longint'(v));
        if (v) begin
            chk({tag, ".ch"},  longint'(bus.Ch_Out), longint'(ch));
            chk({tag, ".out"}, longint'(bus.Error_Out), val);
            chk({tag, ".sat"}, longint'(bus.Sat_Flag), longint'(sat));
        end
    endtask

    initial begin
        longint exp_b [8];
        n_pass  = 0;
        n_fail  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        idle();
        clr(1'b0, 0);
        exp_b = '{1, 2, 3, 4, 2, 4, 6, 8};

        // Reset state
        tick();
        tick();
        chk("rst.valid", longint'(bus.Valid_out_error), 0);
        chk("rst.out",   longint'(bus.Error_Out), 0);
        chk("rst.ch",    longint'(bus.Ch_Out), 0);
        chk("rst.sat",   longint'(bus.Sat_Flag), 0);
        rst_n = 1'b1;

        // A: ch0, R=1000, Data=400, Coeff=2, three samples
        for (int j = 0; j < 7; j++) begin
            if (j < 3) drive(1'b1, 0, 400, 1000, 2, 1'b0);
            else       idle();
            tick();
            if (j < 3) chk_out("a.lat", 1'b0, 0, 0, 1'b0);
            else if (j < 6) chk_out("a.acc", 1'b1, 0, 1200 * (j - 2), 1'b0);
            else begin
                chk_out("a.end", 1'b0, 0, 0, 1'b0);
                chk("a.hold", longint'(bus.Error_Out), 3600);
            end
        end
        clr(1'b1, 0);
        tick();
        clr(1'b0, 0);

        // B: round-robin ch0..3, Coeff=1, R-Data = 1..4, two rounds
        for (int j = 0; j < 11; j++) begin
            if (j < 8) drive(1'b1, j % 4, 100 - (j % 4 + 1), 100, 1, 1'b0);
            else       idle();
            tick();
            if (j >= 3) chk_out("b.rr", 1'b1, (j - 3) % 4, exp_b[j - 3], 1'b0);
        end

        // C: saturation on ch3 (acc starts at 8), then a negative error
        for (int j = 0; j < 22; j++) begin
            if (j < 18)       drive(1'b1, 3, -536870912, 67108863, 131071, 1'b0);
            else if (j == 18) drive(1'b1, 3, 1000, 0, 1, 1'b0);
            else              idle();
            tick();
            if (j - 3 == 15) chk_out("c.pre", 1'b1, 3, 8 + 16 * PROD_C, 1'b0);
            if (j - 3 == 16) chk_out("c.clip", 1'b1, 3, OMAX, 1'b1);
            if (j - 3 == 17) chk_out("c.stay", 1'b1, 3, OMAX, 1'b1);
            if (j - 3 == 18) chk_out("c.dec", 1'b1, 3, OMAX - 1000, 1'b0);
        end

        // D: freeze on ch1 holding 500
        clr(1'b1, 1);
        tick();
        clr(1'b0, 0);
        drive(1'b1, 1, 0, 500, 1, 1'b0); tick();
        drive(1'b1, 1, 0, 7, 3, 1'b1);   tick();
        drive(1'b1, 1, 0, 10, 1, 1'b0);  tick();
        idle();                          tick();
        chk_out("d.set", 1'b1, 1, 500, 1'b0);
        tick();
        chk_out("d.frz", 1'b1, 1, 500, 1'b0);
        tick();
        chk_out("d.after", 1'b1, 1, 510, 1'b0);

        // E: clear ch2 while ch2 is updating, then while ch3 is updating
        drive(1'b1, 2, 0, 5, 1, 1'b0); tick();
        drive(1'b1, 3, 5, 0, 1, 1'b0); tick();
        idle();                        tick();
        clr(1'b1, 2);                  tick();
        chk_out("e.clr", 1'b1, 2, 0, 1'b0);
        tick();
        chk_out("e.other", 1'b1, 3, OMAX - 1005, 1'b0);
        clr(1'b0, 0);
        drive(1'b1, 2, 0, 5, 1, 1'b0); tick();
        idle();
        tick();
        tick();
        tick();
        chk_out("e.zero", 1'b1, 2, 5, 1'b0);

        // F: reset with three samples in flight
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 0, 0, 3, 1, 1'b0);
            tick();
        end
        idle();
        rst_n = 1'b0;
        #1;
        chk("f.async.out", longint'(bus.Error_Out), 0);
        chk("f.async.valid", longint'(bus.Valid_out_error), 0);
        tick();
        chk_out("f.drop0", 1'b0, 0, 0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_out("f.drop1", 1'b0, 0, 0, 1'b0);
        tick();
        chk_out("f.drop2", 1'b0, 0, 0, 1'b0);
        for (int j = 0; j < 7; j++) begin
            if (j < 4) drive(1'b1, j, 0, 0, 1, 1'b0);
            else       idle();
            tick();
            if (j >= 3) chk_out("f.acc", 1'b1, j - 3, 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
